// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: access-type encodings, widths and pipeline register layouts for the memory stage
package mem_stage_pkg;
    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int LANES  = WORD_W / BYTE_W;

    localparam logic [2:0] LS_BYTE_S = 3'b000;
    localparam logic [2:0] LS_HALF_S = 3'b001;
    localparam logic [2:0] LS_WORD   = 3'b010;
    localparam logic [2:0] LS_BYTE_U = 3'b011;
    localparam logic [2:0] LS_HALF_U = 3'b100;

    typedef struct packed {
        logic [WORD_W-1:0] alu;
        logic [WORD_W-1:0] rt;
        logic [WORD_W-1:0] pc;
        logic [4:0]        dst;
        logic              sel;
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_write;
        logic              mem_read;
        logic [2:0]        ls_type;
    } ex_mem_t;

    typedef struct packed {
        logic [WORD_W-1:0] read_data;
        logic [WORD_W-1:0] alu;
        logic [WORD_W-1:0] pc;
        logic [4:0]        dst;
        logic              reg_write;
        logic              mem_to_reg;
        logic              sel;
        logic              misaligned;
    } mem_wb_t;
endpackage

// File: rtl/data_memory.sv
// data_memory: word-organised RAM with byte-enable synchronous write and two combinational read ports
module data_memory
    import mem_stage_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [LANES-1:0]  i_be,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [WORD_W-1:0] o_dbg_data
);
    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < LANES; b++) begin
                if (i_be[b]) mem_q[i_addr][b*BYTE_W +: BYTE_W] <= i_wdata[b*BYTE_W +: BYTE_W];
            end
        end
    end

    assign o_rdata    = mem_q[i_addr];
    assign o_dbg_data = mem_q[i_dbg_addr];
endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM register, byte/half/word data memory access and MEM/WB register
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic [WORD_W-1:0] i_ALU_res,
    input  logic [WORD_W-1:0] i_rt_reg,
    input  logic [WORD_W-1:0] i_pc_to_reg,
    input  logic [4:0]        i_addr_reg_dst,
    input  logic              is_select_addr_reg,
    input  logic              is_RegWrite,
    input  logic              is_MemtoReg,
    input  logic              is_MemWrite,
    input  logic              is_MemRead,
    input  logic [2:0]        is_load_store_type,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [WORD_W-1:0] o_dbg_data,
    output logic [4:0]        o_fwd_addr,
    output logic              o_fwd_RegWrite,
    output logic [WORD_W-1:0] o_fwd_data,
    output logic [WORD_W-1:0] o_read_data,
    output logic [WORD_W-1:0] o_ALU_res,
    output logic [WORD_W-1:0] o_pc_to_reg,
    output logic [4:0]        o_addr_reg_dst,
    output logic              os_RegWrite,
    output logic              os_MemtoReg,
    output logic              os_select_addr_reg,
    output logic              os_misaligned
);
    ex_mem_t           ex_q, ex_d;
    mem_wb_t           wb_q, wb_d;
    logic [1:0]        off;
    logic              is_byte, is_half, is_word, sgn, misaligned, we;
    logic [LANES-1:0]  be;
    logic [WORD_W-1:0] wdata, rdata, shifted, ext, load;

    always_comb begin
        ex_d = '{alu: i_ALU_res, rt: i_rt_reg, pc: i_pc_to_reg, dst: i_addr_reg_dst,
                 sel: is_select_addr_reg, reg_write: is_RegWrite, mem_to_reg: is_MemtoReg,
                 mem_write: is_MemWrite, mem_read: is_MemRead, ls_type: is_load_store_type};
        if (i_flush) begin
            ex_d.sel        = 1'b0;
            ex_d.reg_write  = 1'b0;
            ex_d.mem_to_reg = 1'b0;
            ex_d.mem_write  = 1'b0;
            ex_d.mem_read   = 1'b0;
        end else if (i_stall) begin
            ex_d = ex_q;
        end
    end

    always_comb begin
        off        = ex_q.alu[1:0];
        is_byte    = (ex_q.ls_type == LS_BYTE_S) || (ex_q.ls_type == LS_BYTE_U);
        is_half    = (ex_q.ls_type == LS_HALF_S) || (ex_q.ls_type == LS_HALF_U);
        is_word    = ~is_byte & ~is_half;
        sgn        = (ex_q.ls_type == LS_BYTE_S) || (ex_q.ls_type == LS_HALF_S);
        misaligned = (is_half & off[0]) | (is_word & (off != 2'b00));
        be         = is_byte ? 4'b0001 << off : is_half ? 4'b0011 << off : 4'b1111;
        wdata      = is_byte ? {LANES{ex_q.rt[BYTE_W-1:0]}} : is_half ? {2{ex_q.rt[HALF_W-1:0]}} : ex_q.rt;
        // rst gate keeps a store sitting in EX/MEM from landing on the edge reset is raised
        we         = ex_q.mem_write & ~misaligned & ~i_stall & ~rst;
        shifted    = rdata >> {off, 3'b000};
        ext        = is_byte ? {{(WORD_W-BYTE_W){sgn & shifted[BYTE_W-1]}}, shifted[BYTE_W-1:0]}
                   : is_half ? {{(WORD_W-HALF_W){sgn & shifted[HALF_W-1]}}, shifted[HALF_W-1:0]}
                   : rdata;
        load       = (ex_q.mem_read & ~misaligned) ? ext : '0;
        wb_d       = i_stall ? wb_q
                   : '{read_data: load, alu: ex_q.alu, pc: ex_q.pc, dst: ex_q.dst,
                       reg_write: ex_q.reg_write, mem_to_reg: ex_q.mem_to_reg, sel: ex_q.sel,
                       misaligned: misaligned & (ex_q.mem_read | ex_q.mem_write)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= '0;
            wb_q <= '0;
        end else begin
            ex_q <= ex_d;
            wb_q <= wb_d;
        end
    end

    data_memory #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk       (clk),
        .i_we      (we),
        .i_be      (be),
        .i_addr    (ex_q.alu[ADDR_W+1:2]),
        .i_wdata   (wdata),
        .o_rdata   (rdata),
        .i_dbg_addr(i_dbg_addr),
        .o_dbg_data(o_dbg_data)
    );

    assign o_fwd_addr         = ex_q.dst;
    assign o_fwd_RegWrite     = ex_q.reg_write;
    assign o_fwd_data         = ex_q.alu;
    assign o_read_data        = wb_q.read_data;
    assign o_ALU_res          = wb_q.alu;
    assign o_pc_to_reg        = wb_q.pc;
    assign o_addr_reg_dst     = wb_q.dst;
    assign os_RegWrite        = wb_q.reg_write;
    assign os_MemtoReg        = wb_q.mem_to_reg;
    assign os_select_addr_reg = wb_q.sel;
    assign os_misaligned      = wb_q.misaligned;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table plus stall/flush/reset sequences for mem_stage
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 0, rst = 0, i_stall = 0, i_flush = 0;
    logic [31:0] i_ALU_res = 0, i_rt_reg = 0, i_pc_to_reg = 0;
    logic [4:0]  i_addr_reg_dst = 0;
    logic        is_select_addr_reg = 0, is_RegWrite = 0, is_MemtoReg = 0, is_MemWrite = 0, is_MemRead = 0;
    logic [2:0]  is_load_store_type = 0;
    logic [7:0]  i_dbg_addr = 0;
    logic [31:0] o_dbg_data, o_fwd_data, o_read_data, o_ALU_res, o_pc_to_reg;
    logic [4:0]  o_fwd_addr, o_addr_reg_dst;
    logic        o_fwd_RegWrite, os_RegWrite, os_MemtoReg, os_select_addr_reg, os_misaligned;

    int n_cmp = 0, n_bad = 0;

    mem_stage #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .i_stall(i_stall), .i_flush(i_flush),
        .i_ALU_res(i_ALU_res), .i_rt_reg(i_rt_reg), .i_pc_to_reg(i_pc_to_reg),
        .i_addr_reg_dst(i_addr_reg_dst), .is_select_addr_reg(is_select_addr_reg),
        .is_RegWrite(is_RegWrite), .is_MemtoReg(is_MemtoReg), .is_MemWrite(is_MemWrite),
        .is_MemRead(is_MemRead), .is_load_store_type(is_load_store_type),
        .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data),
        .o_fwd_addr(o_fwd_addr), .o_fwd_RegWrite(o_fwd_RegWrite), .o_fwd_data(o_fwd_data),
        .o_read_data(o_read_data), .o_ALU_res(o_ALU_res), .o_pc_to_reg(o_pc_to_reg),
        .o_addr_reg_dst(o_addr_reg_dst), .os_RegWrite(os_RegWrite), .os_MemtoReg(os_MemtoReg),
        .os_select_addr_reg(os_select_addr_reg), .os_misaligned(os_misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  t;
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        logic [7:0]  idx;
        logic [31:0] rd;
        logic        mis;
        logic [31:0] dbg;
    } vec_t;

    vec_t v[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        i_flush = 0; i_stall = 0;
        is_RegWrite = 0; is_MemtoReg = 0; is_MemWrite = 0; is_MemRead = 0; is_select_addr_reg = 0;
        is_load_store_type = LS_WORD;
        i_ALU_res = 32'h0000_0100; i_rt_reg = 0; i_pc_to_reg = 0; i_addr_reg_dst = 0;
    endtask

    task automatic op(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                      input logic w, input logic [4:0] dst);
        nop();
        is_load_store_type = t; i_ALU_res = a; i_rt_reg = d;
        i_pc_to_reg = a + 32'd4; i_addr_reg_dst = dst;
        is_MemWrite = w; is_MemRead = ~w; is_RegWrite = ~w; is_MemtoReg = ~w;
    endtask

    initial begin
        v[0]  = '{LS_WORD,   32'h10, 32'hDEADBEEF, 1, 8'd4, 32'h0,        0, 32'hDEADBEEF};
        v[1]  = '{LS_WORD,   32'h10, 32'h0,        0, 8'd4, 32'hDEADBEEF, 0, 32'hDEADBEEF};
        v[2]  = '{LS_BYTE_S, 32'h13, 32'h0,        0, 8'd4, 32'hFFFFFFDE, 0, 32'hDEADBEEF};
        v[3]  = '{LS_BYTE_U, 32'h13, 32'h0,        0, 8'd4, 32'h000000DE, 0, 32'hDEADBEEF};
        v[4]  = '{LS_HALF_S, 32'h12, 32'h0,        0, 8'd4, 32'hFFFFDEAD, 0, 32'hDEADBEEF};
        v[5]  = '{LS_HALF_U, 32'h10, 32'h0,        0, 8'd4, 32'h0000BEEF, 0, 32'hDEADBEEF};
        v[6]  = '{LS_BYTE_S, 32'h11, 32'hAAAAAA55, 1, 8'd4, 32'h0,        0, 32'hDEAD55EF};
        v[7]  = '{LS_HALF_U, 32'h12, 32'hFFFF1234, 1, 8'd4, 32'h0,        0, 32'h123455EF};
        v[8]  = '{LS_WORD,   32'h14, 32'hCAFEF00D, 1, 8'd5, 32'h0,        0, 32'hCAFEF00D};
        v[9]  = '{LS_WORD,   32'h16, 32'h11111111, 1, 8'd5, 32'h0,        1, 32'hCAFEF00D};
        v[10] = '{LS_HALF_S, 32'h11, 32'h0,        0, 8'd4, 32'h0,        1, 32'h123455EF};
        v[11] = '{3'b111,    32'h14, 32'h0,        0, 8'd5, 32'hCAFEF00D, 0, 32'hCAFEF00D};
        v[12] = '{LS_BYTE_S, 32'h10, 32'h0,        0, 8'd4, 32'hFFFFFFEF, 0, 32'h123455EF};
        v[13] = '{LS_HALF_S, 32'h12, 32'h0,        0, 8'd4, 32'h00001234, 0, 32'h123455EF};
        v[14] = '{LS_WORD,   32'h18, 32'h00000000, 1, 8'd6, 32'h0,        0, 32'h00000000};

        op(LS_WORD, 32'hFFFF_FFFF, 32'h1234_5678, 0, 5'd31);
        is_select_addr_reg = 1;
        rst = 1;
        step(); step();
        chk("rst_read_data", o_read_data, 0);
        chk("rst_alu", o_ALU_res, 0);
        chk("rst_pc", o_pc_to_reg, 0);
        chk("rst_dst", {27'd0, o_addr_reg_dst}, 0);
        chk("rst_fwd_data", o_fwd_data, 0);
        chk("rst_fwd", {o_fwd_addr, o_fwd_RegWrite}, 0);
        chk("rst_ctl", {os_RegWrite, os_MemtoReg, os_select_addr_reg, os_misaligned}, 0);
        nop();
        rst = 0;
        step();

        for (int i = 0; i < 15; i++) begin
            op(v[i].t, v[i].a, v[i].d, v[i].w, 5'(i + 1));
            i_dbg_addr = v[i].idx;
            step();
            chk($sformatf("v%0d_fwd_data", i), o_fwd_data, v[i].a);
            chk($sformatf("v%0d_fwd_addr", i), {27'd0, o_fwd_addr}, 32'(i + 1));
            chk($sformatf("v%0d_fwd_rw", i), {31'd0, o_fwd_RegWrite}, {31'd0, ~v[i].w});
            nop();
            step();
            chk($sformatf("v%0d_read_data", i), o_read_data, v[i].rd);
            chk($sformatf("v%0d_misaligned", i), {31'd0, os_misaligned}, {31'd0, v[i].mis});
            chk($sformatf("v%0d_memtoreg", i), {31'd0, os_MemtoReg}, {31'd0, ~v[i].w});
            chk($sformatf("v%0d_regwrite", i), {31'd0, os_RegWrite}, {31'd0, ~v[i].w});
            chk($sformatf("v%0d_alu", i), o_ALU_res, v[i].a);
            chk($sformatf("v%0d_pc", i), o_pc_to_reg, v[i].a + 32'd4);
            chk($sformatf("v%0d_dbg", i), o_dbg_data, v[i].dbg);
        end

        // store held in EX/MEM by a 3-cycle stall must write exactly once, after release
        i_dbg_addr = 8'd6;
        op(LS_WORD, 32'h18, 32'h0BADF00D, 1, 5'd9);
        step();
        nop();
        i_ALU_res = 32'h44;
        i_stall = 1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("stall%0d_dbg", c), o_dbg_data, 32'h0);
            chk($sformatf("stall%0d_fwd_hold", c), o_fwd_data, 32'h18);
        end
        nop();
        step();
        chk("stall_release_dbg", o_dbg_data, 32'h0BADF00D);
        chk("stall_release_alu", o_ALU_res, 32'h18);
        step();
        chk("stall_after_dbg", o_dbg_data, 32'h0BADF00D);

        op(LS_WORD, 32'h18, 32'h77777777, 1, 5'd10);
        is_RegWrite = 1;
        i_flush = 1;
        step();
        chk("flush_fwd_rw", {31'd0, o_fwd_RegWrite}, 0);
        nop();
        step();
        chk("flush_regwrite", {31'd0, os_RegWrite}, 0);
        chk("flush_dbg", o_dbg_data, 32'h0BADF00D);
        step();
        chk("flush_dbg_late", o_dbg_data, 32'h0BADF00D);

        // reset raised while a store sits in EX/MEM
        op(LS_WORD, 32'h18, 32'h55AA55AA, 1, 5'd11);
        step();
        nop();
        #2 rst = 1;
        #1;
        chk("midrst_fwd_data", o_fwd_data, 0);
        chk("midrst_alu", o_ALU_res, 0);
        step();
        chk("midrst_dbg", o_dbg_data, 32'h0BADF00D);
        rst = 0;
        step();
        chk("midrst_after_dbg", o_dbg_data, 32'h0BADF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
